multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle main control FSM for the MIPS core. It is the producer of the 3-bit ALU opcode and 6-bit function field that the ALU control decoder consumes.
- Accepts one 32-bit instruction per handshake and latches it into an internal instruction register.
- Classifies the instruction as R-type ADD/SUB/OR or I-type ADDI/LUI/ORI, sequences FETCH→DECODE→EXEC→WB, and drives datapath controls.
- Flags unsupported encodings and counts retired and illegal instructions.

Parameters:
- COUNT_WIDTH, 16, width of the retired and illegal instruction counters; both wrap modulo 2^COUNT_WIDTH.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid_i  input  1  instruction source has a valid word on instr_i.
- instr_i  input  32  instruction word.
- instr_ready_o  output  1  unit can accept an instruction.
- alu_op_o  output  3  ALU opcode: 111 R-type, 100 ADDI, 001 LUI, 010 ORI, 000 none.
- alu_function_o  output  6  IR[5:0] when the current instruction is R-type, else 000000.
- alu_src_o  output  1  1 selects the immediate as ALU operand B.
- reg_dst_o  output  1  1 selects rd as destination, 0 selects rt.
- reg_write_o  output  1  register-file write strobe.
- rs_o  output  5  IR[25:21].
- rt_o  output  5  IR[20:16].
- write_reg_o  output  5  rd if reg_dst_o, else rt.
- imm_o  output  16  IR[15:0].
- illegal_o  output  1  one-cycle pulse for an unsupported instruction.
- retired_count_o  output  COUNT_WIDTH  number of instructions retired.
- illegal_count_o  output  COUNT_WIDTH  number of illegal instructions seen.

Behaviour:
- States: FETCH, DECODE, EXEC, WB, TRAP, encoded in a registered state variable.
- Outputs are Moore: functions of state and IR only, except that reset forces instr_ready_o to 0.
- Reset (sampled at clk edge while reset=1):
  - state←FETCH, IR←0, both counters←0.
  - While reset is high: instr_ready_o=0, reg_write_o=0, illegal_o=0, alu_op_o=000.
- FETCH: instr_ready_o=1.
  - If instr_valid_i=1, handshake completes: IR←instr_i, go to DECODE.
  - Otherwise stay in FETCH.
  - instr_i is ignored outside a handshake.
- DECODE: instr_ready_o=0. Classify IR:
  - op 000000 with funct 100000/100010/100101 → legal R-type.
  - op 001000 → ADDI; op 001111 → LUI; op 001101 → ORI.
  - Legal → EXEC. Anything else, including R-type with another funct → TRAP.
- EXEC: alu_op_o and alu_src_o/reg_dst_o valid per the class table below; next state WB.
- WB: same control values as EXEC held stable; reg_write_o=1 for exactly this cycle; retired_count_o increments; next state FETCH.
- TRAP: illegal_o=1 for one cycle; illegal_count_o increments; reg_write_o=0; next state FETCH.
- Class table:
  - R-type: alu_op 111, alu_src 0, reg_dst 1, alu_function = funct.
  - ADDI: alu_op 100, alu_src 1, reg_dst 0.
  - LUI: alu_op 001, alu_src 1, reg_dst 0.
  - ORI: alu_op 010, alu_src 1, reg_dst 0.
  - I-type alu_function_o = 000000.
- In FETCH, DECODE and TRAP: alu_op_o=000, alu_src_o=0, reg_dst_o=0, reg_write_o=0.
- rs_o, rt_o, imm_o and write_reg_o always reflect the IR.
- Timing:
  - Handshake at edge T → DECODE in cycle T+1, EXEC T+2, WB T+3, FETCH T+4.
  - Throughput is one instruction per 4 cycles; TRAP path is 3 cycles.
- Counters wrap silently from all-ones to 0.
- Reset mid-operation, in any state:
  - No reg_write_o or illegal_o pulse for the aborted instruction.
  - Its counter does not increment.
  - First handshake is possible on the first edge after reset deasserts.
- instr_valid_i held high continuously: one instruction is accepted per FETCH visit only.

Test Plan:
- Reset, then add $t0,$t1,$t2 (0x012A4020) with valid at edge T:
  - alu_op_o=111, alu_function_o=100000, reg_dst_o=1, alu_src_o=0, write_reg_o=8 in T+2..T+3.
  - reg_write_o=1 only in T+3; retired_count_o=1; instr_ready_o=1 at T+4.
- addi $t0,$t1,5 (0x21280005):
  - alu_op_o=100, alu_src_o=1, reg_dst_o=0, write_reg_o=8, imm_o=0x0005, alu_function_o=000000.
- Back-to-back lui $t0,0x1234 (0x3C081234) then ori $t0,$t0,0xFFFF (0x3508FFFF), valid held high:
  - alu_op 001 then 010; second handshake exactly 4 cycles after first; retired_count_o=2.
- lw (0x8D280000), then slt R-type (0x012A402A):
  - illegal_o pulses at T+2 for each; reg_write_o never asserts; illegal_count_o=2; retired_count_o unchanged.
- Assert reset during EXEC of an ADD:
  - No reg_write_o pulse; counters=0; instr_ready_o=0 while reset=1, then 1 the cycle after release.
- COUNT_WIDTH=2: retire 5 ADDIs → retired_count_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM: latches one instruction per handshake, steps it
// through DECODE/EXEC/WB (or TRAP), and drives the ALU and register-file controls.
module multicycle_control_unit #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid_i,
    input  logic [31:0]            instr_i,
    output logic                   instr_ready_o,
    output logic [2:0]             alu_op_o,
    output logic [5:0]             alu_function_o,
    output logic                   alu_src_o,
    output logic                   reg_dst_o,
    output logic                   reg_write_o,
    output logic [4:0]             rs_o,
    output logic [4:0]             rt_o,
    output logic [4:0]             write_reg_o,
    output logic [15:0]            imm_o,
    output logic                   illegal_o,
    output logic [COUNT_WIDTH-1:0] retired_count_o,
    output logic [COUNT_WIDTH-1:0] illegal_count_o
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;

    state_t                 state_q, state_d;
    logic [31:0]            ir_q, ir_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic [COUNT_WIDTH-1:0] illegal_cnt_q, illegal_cnt_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       cls_legal;
    logic [2:0] cls_alu_op;
    logic       cls_alu_src;
    logic       cls_reg_dst;
    logic       exec_phase;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // Instruction classification from the instruction register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cls_legal   = 1'b0;
        cls_alu_op  = 3'b000;
        cls_alu_src = 1'b0;
        cls_reg_dst = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FUNCT_ADD || funct == FUNCT_SUB || funct == FUNCT_OR) begin
                    cls_legal   = 1'b1;
                    cls_alu_op  = 3'b111;
                    cls_reg_dst = 1'b1;
                end
            end
            OP_ADDI: begin
                cls_legal   = 1'b1;
                cls_alu_op  = 3'b100;
                cls_alu_src = 1'b1;
            end
            OP_LUI: begin
                cls_legal   = 1'b1;
                cls_alu_op  = 3'b001;
                cls_alu_src = 1'b1;
            end
            OP_ORI: begin
                cls_legal   = 1'b1;
                cls_alu_op  = 3'b010;
                cls_alu_src = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        retired_d     = retired_q;
        illegal_cnt_d = illegal_cnt_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid_i) begin
                    ir_d    = instr_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = cls_legal ? S_EXEC : S_TRAP;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                retired_d = retired_q + COUNT_WIDTH'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal_cnt_d = illegal_cnt_q + COUNT_WIDTH'(1);
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Control values are held identical across EXEC and WB; strobes are masked by reset.
    assign exec_phase = (state_q == S_EXEC) || (state_q == S_WB);

    always_comb begin
        instr_ready_o  = !reset && (state_q == S_FETCH);
        alu_op_o       = (exec_phase && !reset) ? cls_alu_op : 3'b000;
        alu_src_o      = exec_phase && cls_alu_src;
        reg_dst_o      = exec_phase && cls_reg_dst;
        reg_write_o    = !reset && (state_q == S_WB);
        illegal_o      = !reset && (state_q == S_TRAP);
        alu_function_o = (opcode == OP_RTYPE) ? funct : 6'b000000;
        rs_o           = ir_q[25:21];
        rt_o           = ir_q[20:16];
        imm_o          = ir_q[15:0];
        write_reg_o    = reg_dst_o ? ir_q[15:11] : ir_q[20:16];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q       <= S_FETCH;
            ir_q          <= '0;
            retired_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            retired_q     <= retired_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign retired_count_o = retired_q;
    assign illegal_count_o = illegal_cnt_q;

endmodule
